// File: rtl/song_sel_pkg.sv
// Shared definitions for the song-select front end and the learning-mode player.
package song_sel_pkg;

  localparam int unsigned NUM_SONGS_DEF = 4;
  localparam int unsigned ID_W_DEF      = 5;
  localparam int unsigned PAGE_W        = 2;

  // Page encoding shared with the player's page decode; 2'b11 is never produced.
  typedef enum logic [PAGE_W-1:0] {
    PAGE_IDLE = 2'b00,
    PAGE_NEXT = 2'b01,
    PAGE_PREV = 2'b10
  } page_e;

  typedef enum logic {
    BTN_IDLE    = 1'b0,
    BTN_PRESSED = 1'b1
  } btn_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, counter-qualified IDLE/PRESSED state and
// a single-cycle rising-edge output.
module btn_debounce
  import song_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned CNT_W           = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  btn_state_e       r_state;
  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_stable_d;
  logic             w_stable;
  logic             w_diff;

  assign w_stable = (r_state == BTN_PRESSED);
  assign w_diff   = (r_s2 != w_stable);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_state    <= BTN_IDLE;
      r_cnt      <= '0;
      r_stable_d <= 1'b0;
    end else begin
      r_s1       <= i_btn;
      r_s2       <= r_s1;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stable_d <= w_stable;
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples;
  // any return to the stable level clears the count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    if (w_diff) begin
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = (r_state == BTN_PRESSED) ? BTN_IDLE : BTN_PRESSED;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rise_c = w_stable & ~r_stable_d;

endmodule

// File: rtl/song_select_ctrl.sv
// Song-select front end: debounced prev/next buttons drive a wrapping song index
// and one-cycle page / update strobes for the player.
module song_select_ctrl
  import song_sel_pkg::*;
#(
  parameter int unsigned NUM_SONGS       = NUM_SONGS_DEF,
  parameter int unsigned ID_W            = ID_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned CNT_W           = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_prev,
  input  logic              btn_next,
  output logic [PAGE_W-1:0] page_pulse,
  output logic [ID_W-1:0]   song_id,
  output logic              sel_update
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SONGS - 1);

  logic              w_rise_prev;
  logic              w_rise_next;
  page_e             w_page_nxt;
  logic [ID_W-1:0]   w_id_nxt;
  logic [PAGE_W-1:0] r_page_pulse;
  logic [ID_W-1:0]   r_song_id;
  logic              r_sel_update;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_prev (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_prev),
    .o_rise_c(w_rise_prev)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_next),
    .o_rise_c(w_rise_next)
  );

  // Simultaneous rises are ambiguous and dropped; the index wraps at both ends.
  always_comb begin
    w_page_nxt = PAGE_IDLE;
    w_id_nxt   = r_song_id;
    unique case ({w_rise_prev, w_rise_next})
      2'b01: begin
        w_page_nxt = PAGE_NEXT;
        w_id_nxt   = (r_song_id == LAST_ID) ? '0 : r_song_id + ID_W'(1);
      end
      2'b10: begin
        w_page_nxt = PAGE_PREV;
        w_id_nxt   = (r_song_id == '0) ? LAST_ID : r_song_id - ID_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page_pulse <= PAGE_IDLE;
      r_song_id    <= '0;
      r_sel_update <= 1'b0;
    end else begin
      r_page_pulse <= w_page_nxt;
      r_song_id    <= w_id_nxt;
      r_sel_update <= (w_page_nxt != PAGE_IDLE);
    end
  end

  assign page_pulse = r_page_pulse;
  assign song_id    = r_song_id;
  assign sel_update = r_sel_update;

endmodule
